// File: rtl/rx_capture_pkg.sv
// rx_capture_pkg: state encoding, channel count and write-word layout shared by the capture scheduler.
package rx_capture_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  localparam int NUM_CH = 4;
  // wr_data field offsets for the default 12-bit sample width
  localparam int DATA_WIDTH_DEF = 12;
  localparam int Q_LSB = 0;
  localparam int I_LSB = DATA_WIDTH_DEF;
  localparam int CH_MSB = 2 * DATA_WIDTH_DEF + 1;
endpackage

// File: rtl/rx_capture_sched_rr_arbiter4.sv
// rr_arbiter4: grants the first requester at or above ptr, wrapping modulo 4; one grant per cycle.
module rr_arbiter4
  import rx_capture_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic       gnt_valid,
  output logic [1:0] gnt_idx
);
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx = ptr;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (en && req[ptr + 2'(i)]) begin
        gnt_valid = 1'b1;
        gnt_idx = ptr + 2'(i);
      end
  end
endmodule

// File: rtl/rx_capture_sched.sv
// rx_capture_sched: sequences a capture window and round-robins four RX channels into one tagged buffer write stream.
module rx_capture_sched
  import rx_capture_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                      d_clk,
  input  logic                      reset,
  input  logic                      arm,
  input  logic                      abort,
  input  logic [ADDR_WIDTH:0]       cfg_len,
  input  logic [3:0]                din_valid,
  input  logic [4*DATA_WIDTH-1:0]   din_i,
  input  logic [4*DATA_WIDTH-1:0]   din_q,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [2+2*DATA_WIDTH-1:0] wr_data,
  output logic                      busy,
  output logic                      done,
  output logic [3:0]                overflow,
  output logic [1:0]                state
);
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  state_t st, st_n;
  logic start, trig, cap, last, en, gnt_valid;
  logic [1:0] gnt_idx, ptr;
  logic [ADDR_WIDTH:0] len_q, cnt;
  logic [NUM_CH-1:0] full, gnt_oh, keep, ld;
  logic [DATA_WIDTH-1:0] hi [NUM_CH];
  logic [DATA_WIDTH-1:0] hq [NUM_CH];

  rr_arbiter4 u_arb (.req(full), .ptr(ptr), .en(en), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx));

  assign state = st;

  always_ff @(posedge d_clk)
    if (reset) st <= IDLE;
    else st <= st_n;

  always_comb begin
    start = arm && !abort && (st == IDLE || st == DONE);
    trig = !abort && st == ARMED && |din_valid;
    cap = !abort && st == CAPTURE;
    en = cap && cnt < len_q;
    last = gnt_valid && cnt + 1'b1 == len_q;
    gnt_oh = gnt_valid ? NUM_CH'(1) << gnt_idx : '0;
    // a channel stays occupied only if it was full and not drained this cycle
    keep = full & ~gnt_oh;
    ld = din_valid & {NUM_CH{trig || cap}};
    st_n = st;
    if (abort) st_n = IDLE;
    else if (start) st_n = cfg_len == '0 ? DONE : ARMED;
    else if (trig) st_n = CAPTURE;
    else if (last) st_n = DONE;
  end

  always_ff @(posedge d_clk)
    if (reset) begin
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      overflow <= '0;
      full <= '0;
      ptr <= '0;
      len_q <= '0;
      cnt <= '0;
    end else begin
      wr_en <= gnt_valid;
      busy <= st_n == ARMED || st_n == CAPTURE;
      done <= st_n == DONE;
      overflow <= start ? '0 : overflow | (ld & keep);
      full <= (abort || last) ? '0 : keep | ld;
      if (gnt_valid) begin
        wr_addr <= cnt[ADDR_WIDTH-1:0];
        wr_data <= {gnt_idx, hi[gnt_idx], hq[gnt_idx]};
        cnt <= cnt + 1'b1;
        ptr <= gnt_idx + 1'b1;
      end
      if (start) begin
        len_q <= cfg_len > DEPTH ? DEPTH : cfg_len;
        cnt <= '0;
        wr_addr <= '0;
      end
    end

  always_ff @(posedge d_clk)
    for (int k = 0; k < NUM_CH; k++)
      if (ld[k] && !keep[k]) begin
        hi[k] <= din_i[k*DATA_WIDTH +: DATA_WIDTH];
        hq[k] <= din_q[k*DATA_WIDTH +: DATA_WIDTH];
      end
endmodule

// File: tb/tb_rx_capture_sched.sv
// tb_rx_capture_sched: directed and randomized capture sequences checked cycle by cycle against a behavioural model.
module tb_rx_capture_sched;
  import rx_capture_pkg::*;
  localparam int DW = 12;
  localparam int AW = 12;
  logic d_clk = 1'b0, reset = 1'b1, arm = 1'b0, abort = 1'b0;
  logic [AW:0] cfg_len = '0;
  logic [3:0] din_valid = '0;
  logic [4*DW-1:0] din_i = '0, din_q = '0;
  logic wr_en, busy, done;
  logic [AW-1:0] wr_addr;
  logic [2+2*DW-1:0] wr_data;
  logic [3:0] overflow;
  logic [1:0] state;
  int checks = 0, errors = 0;
  int m_state, m_len, m_cnt, m_ptr;
  bit m_full [4];
  logic [DW-1:0] m_i [4];
  logic [DW-1:0] m_q [4];
  logic e_wr_en;
  logic [AW-1:0] e_wr_addr;
  logic [2+2*DW-1:0] e_wr_data;
  logic [3:0] e_ovf;
  int data_mode = 0, seq = 0, n_wr = 0;
  int ch_log [$];
  int i_log [$];
  int q_log [$];
  int addr_log [$];

  always #5 d_clk = ~d_clk;

  rx_capture_sched dut (
    .d_clk(d_clk), .reset(reset), .arm(arm), .abort(abort), .cfg_len(cfg_len),
    .din_valid(din_valid), .din_i(din_i), .din_q(din_q), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow), .state(state)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_len = 0; m_cnt = 0; m_ptr = 0;
    m_full = '{default: 0};
    e_wr_en = 1'b0; e_wr_addr = '0; e_wr_data = '0; e_ovf = '0;
  endtask

  // one clock of the capture rules: drain one held sample, absorb new samples, then move the sequence on
  task automatic model_step();
    bit g_ok = 0;
    int g = 0;
    if (m_state == 2 && !abort && m_cnt < m_len)
      for (int n = 0; n < 4; n++)
        if (!g_ok && m_full[(m_ptr + n) % 4]) begin g_ok = 1; g = (m_ptr + n) % 4; end
    e_wr_en = g_ok;
    if (g_ok) begin
      e_wr_addr = AW'(m_cnt);
      e_wr_data = {2'(g), m_i[g], m_q[g]};
      m_full[g] = 0;
      m_cnt++;
      m_ptr = (g + 1) % 4;
    end
    if (!abort && (m_state == 2 || (m_state == 1 && din_valid != 0)))
      for (int k = 0; k < 4; k++)
        if (din_valid[k]) begin
          if (m_full[k]) e_ovf[k] = 1'b1;
          else begin m_full[k] = 1; m_i[k] = din_i[k*DW +: DW]; m_q[k] = din_q[k*DW +: DW]; end
        end
    if (abort) begin m_state = 0; m_full = '{default: 0}; end
    else if (arm && (m_state == 0 || m_state == 3)) begin
      m_len = cfg_len > 4096 ? 4096 : int'(cfg_len);
      m_cnt = 0; e_wr_addr = '0; e_ovf = '0;
      m_state = cfg_len == 0 ? 3 : 1;
    end
    else if (m_state == 1 && din_valid != 0) m_state = 2;
    else if (m_state == 2 && g_ok && m_cnt == m_len) begin m_state = 3; m_full = '{default: 0}; end
  endtask

  task automatic step();
    if (reset) model_reset(); else model_step();
    @(posedge d_clk);
    #1;
    chk("state", 32'(state), 32'(m_state));
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(e_wr_addr));
    chk("wr_data", 32'(wr_data), 32'(e_wr_data));
    chk("done", 32'(done), 32'(m_state == 3));
    chk("busy", 32'(busy), 32'(m_state == 1 || m_state == 2));
    chk("overflow", 32'(overflow), 32'(e_ovf));
    if (wr_en) begin
      n_wr++;
      ch_log.push_back(int'(wr_data[CH_MSB -: 2]));
      i_log.push_back(int'(wr_data[I_LSB +: DW]));
      q_log.push_back(int'(wr_data[Q_LSB +: DW]));
      addr_log.push_back(int'(wr_addr));
    end
  endtask

  task automatic drive(bit a, bit ab, int len, logic [3:0] v);
    arm = a; abort = ab; cfg_len = (AW+1)'(len); din_valid = v;
    din_i = 48'({$urandom(), $urandom()});
    din_q = 48'({$urandom(), $urandom()});
    for (int k = 0; k < 4; k++)
      if (data_mode == 1) begin
        din_i[k*DW +: DW] = DW'(32'h100 + k);
        din_q[k*DW +: DW] = DW'(32'h200 + k);
      end else if (data_mode == 2) din_i[k*DW +: DW] = DW'(seq);
    seq++;
    step();
  endtask

  task automatic clear_logs();
    n_wr = 0;
    ch_log.delete(); i_log.delete(); q_log.delete(); addr_log.delete();
  endtask

  initial begin
    repeat (3) drive(0, 0, 0, 4'h0);
    reset = 1'b0;
    clear_logs();
    data_mode = 1;
    drive(1, 0, 8, 4'h0);
    for (int c = 0; c < 14; c++) drive(0, 0, 0, (c % 4 == 0) ? 4'hF : 4'h0);
    chk("t1_nwr", 32'(n_wr), 8);
    for (int j = 0; j < 8; j++) begin
      chk("t1_ch", 32'(ch_log[j]), 32'(j % 4));
      chk("t1_addr", 32'(addr_log[j]), 32'(j));
      chk("t1_i", 32'(i_log[j]), 32'(32'h100 + j % 4));
      chk("t1_q", 32'(q_log[j]), 32'(32'h200 + j % 4));
    end
    chk("t1_done", 32'(done), 1);
    chk("t1_ovf", 32'(overflow), 0);
    clear_logs();
    data_mode = 2;
    drive(1, 0, 4, 4'h0);
    for (int c = 0; c < 10; c++) drive(0, 0, 0, 4'b0100);
    chk("t2_nwr", 32'(n_wr), 4);
    for (int j = 0; j < 4; j++) chk("t2_ch", 32'(ch_log[j]), 2);
    clear_logs();
    data_mode = 0;
    drive(1, 0, 0, 4'h0);
    chk("t3_state", 32'(state), 3);
    for (int c = 0; c < 5; c++) drive(0, 0, 0, 4'hF);
    chk("t3_nwr", 32'(n_wr), 0);
    clear_logs();
    drive(1, 0, 4097, 4'h0);
    for (int c = 0; c < 4300 && state != 2'd3; c++) drive(0, 0, 0, 4'hF);
    chk("t4_nwr", 32'(n_wr), 4096);
    chk("t4_last_addr", 32'(addr_log[$]), 32'hFFF);
    chk("t4_state", 32'(state), 3);
    clear_logs();
    drive(1, 0, 16, 4'h0);
    for (int c = 0; c < 20 && n_wr < 3; c++) drive(0, 0, 0, 4'hF);
    drive(0, 1, 0, 4'hF);
    chk("t5_abort_state", 32'(state), 0);
    chk("t5_ovf_kept", 32'(overflow != 0), 1);
    clear_logs();
    drive(1, 0, 2, 4'h0);
    chk("t5_ovf_cleared", 32'(overflow), 0);
    for (int c = 0; c < 6; c++) drive(0, 0, 0, 4'hF);
    chk("t5_nwr", 32'(n_wr), 2);
    chk("t5_addr0", 32'(addr_log[0]), 0);
    chk("t5_addr1", 32'(addr_log[1]), 1);
    chk("t6_pre_done", 32'(state), 3);
    drive(1, 1, 5, 4'h0);
    chk("t6_state", 32'(state), 0);
    chk("t6_done", 32'(done), 0);
    for (int c = 0; c < 800; c++)
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 20), 4'($urandom()));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
